// File: rtl/simon_ser_pkg.sv
// Shared types and sizing helpers for the Simon share serialiser.
package simon_ser_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StRun,
        StUnload,
        StDone
    } state_e;

    localparam int unsigned DefNshares = 3;
    localparam int unsigned DefInW     = 256;
    localparam int unsigned DefOutW    = 128;
    localparam int unsigned DefTimeout = 4096;

    // Counter width that can hold the longest phase without wrapping.
    function automatic int unsigned CNT_W(input int unsigned a, input int unsigned b,
                                          input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/simon_share_serdes_if.sv
// Host-side parallel bus of the share serialiser.
interface simon_share_serdes_if #(
    parameter int unsigned NSHARES = 3,
    parameter int unsigned IN_W    = 256,
    parameter int unsigned OUT_W   = 128
);
    logic [NSHARES*IN_W-1:0] Din;
    logic                    Drdy;
    logic [OUT_W-1:0]        Dout;
    logic                    Dvld;
    logic                    BSY;
    logic                    Err;

    modport master (output Din, Drdy, input Dout, Dvld, BSY, Err);
    modport slave  (input Din, Drdy, output Dout, Dvld, BSY, Err);
endinterface

// File: rtl/share_shift_reg.sv
// Parallel-load, right-shifting register used for one share lane.
module share_shift_reg #(
    parameter int unsigned W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         en_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         shift_i,
    input  logic         sin_i,
    output logic [W-1:0] q_o,
    output logic         sout_o
);
    logic [W-1:0] q_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            q_q <= '0;
        end else if (en_i) begin
            if (load_i) begin
                q_q <= load_val_i;
            end else if (shift_i) begin
                q_q <= {sin_i, q_q[W-1:1]};
            end
        end
    end

    assign q_o    = q_q;
    assign sout_o = q_q[0];
endmodule

// File: rtl/simon_share_serdes.sv
// Streams latched input shares LSB-first into a bit-serial Simon core and
// collects the serial output shares into a recombined parallel result.
module simon_share_serdes
    import simon_ser_pkg::*;
#(
    parameter int unsigned NSHARES = DefNshares,
    parameter int unsigned IN_W    = DefInW,
    parameter int unsigned OUT_W   = DefOutW,
    parameter int unsigned MASKED  = 1,
    parameter int unsigned TIMEOUT = DefTimeout
) (
    input  logic               CLK,
    input  logic               RSTn,
    input  logic               EN,
    simon_share_serdes_if.slave host,
    output logic [NSHARES-1:0] core_din,
    output logic               core_load,
    output logic               core_run,
    input  logic [NSHARES-1:0] core_dout,
    input  logic               core_done
);
    localparam int unsigned CntW = CNT_W(IN_W, OUT_W, TIMEOUT);

    state_e            state_q;
    logic [CntW-1:0]   cnt_q;
    logic [OUT_W-1:0]  dout_q;
    logic              dvld_q;
    logic              err_q;

    logic               start;
    logic               in_shift;
    logic               out_shift;
    logic [NSHARES-1:0] in_bit;
    logic [OUT_W-1:0]   out_q [NSHARES];
    logic [OUT_W-1:0]   dout_next;
    logic [IN_W-1:0]    unused_in_q [NSHARES];
    logic [NSHARES-1:0] unused_out_bit;

    assign start     = (state_q == StIdle) && host.Drdy;
    assign in_shift  = (state_q == StLoad);
    assign out_shift = (state_q == StUnload);

    for (genvar s = 0; s < NSHARES; s++) begin : g_share
        share_shift_reg #(.W(IN_W)) u_in (
            .clk_i      (CLK),
            .rst_ni     (RSTn),
            .en_i       (EN),
            .load_i     (start),
            .load_val_i (host.Din[s*IN_W +: IN_W]),
            .shift_i    (in_shift),
            .sin_i      (1'b0),
            .q_o        (unused_in_q[s]),
            .sout_o     (in_bit[s])
        );

        // Output lanes are cleared on start so a short unload can't leak old data.
        share_shift_reg #(.W(OUT_W)) u_out (
            .clk_i      (CLK),
            .rst_ni     (RSTn),
            .en_i       (EN),
            .load_i     (start),
            .load_val_i ('0),
            .shift_i    (out_shift),
            .sin_i      (core_dout[s]),
            .q_o        (out_q[s]),
            .sout_o     (unused_out_bit[s])
        );
    end

    // Recombine using the post-shift lane values so Dout is ready in DONE.
    always_comb begin
        dout_next = '0;
        for (int s = 0; s < int'(NSHARES); s++) begin
            if (MASKED != 0 || s == 0) begin
                dout_next ^= {core_dout[s], out_q[s][OUT_W-1:1]};
            end
        end
    end

    always_comb begin
        core_din = '0;
        if (state_q == StLoad) begin
            if (MASKED != 0) core_din = in_bit;
            else             core_din[0] = ^in_bit;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            dout_q  <= '0;
            dvld_q  <= 1'b0;
            err_q   <= 1'b0;
        end else if (EN) begin
            dvld_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (host.Drdy) begin
                        state_q <= StLoad;
                        cnt_q   <= '0;
                        err_q   <= 1'b0;
                    end
                end
                StLoad: begin
                    if (cnt_q == CntW'(IN_W - 1)) begin
                        state_q <= StRun;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StRun: begin
                    if (core_done) begin
                        state_q <= StUnload;
                        cnt_q   <= '0;
                    end else if ((TIMEOUT != 0) && (cnt_q == CntW'(TIMEOUT - 1))) begin
                        state_q <= StIdle;
                        cnt_q   <= '0;
                        err_q   <= 1'b1;
                    end else if (cnt_q != '1) begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StUnload: begin
                    if (cnt_q == CntW'(OUT_W - 1)) begin
                        state_q <= StDone;
                        cnt_q   <= '0;
                        dout_q  <= dout_next;
                        dvld_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign core_load = (state_q == StLoad);
    assign core_run  = (state_q == StRun);
    assign host.Dout = dout_q;
    assign host.Dvld = dvld_q;
    assign host.BSY  = (state_q != StIdle);
    assign host.Err  = err_q;
endmodule

// File: tb/tb_simon_share_serdes.sv
// Drives a masked and an unmasked serialiser in lockstep against loopback core models.
module tb_simon_share_serdes;
    localparam int unsigned NS     = 3;
    localparam int unsigned IW     = 256;
    localparam int unsigned OW     = 128;
    localparam int unsigned TO     = 16;
    localparam int unsigned RunLen = 10;

    logic          CLK = 1'b0;
    logic          RSTn;
    logic          EN;
    logic [NS*IW-1:0] din_tb;
    logic          drdy_tb;
    logic          silent;
    logic          extra_done;

    int cyc = 0;
    int checks = 0;
    int failures = 0;
    int dvld_cnt = 0;
    int dvld_cyc = 0;
    int lane_err = 0;
    logic [OW-1:0] exp_q[$];

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        simon_share_serdes_if #(.NSHARES(NS), .IN_W(IW), .OUT_W(OW)) bus ();

        logic [NS-1:0] cdin;
        logic [NS-1:0] cdout;
        logic          cload;
        logic          crun;
        logic          cdone;
        logic [7:0]    stat;
        logic [OW-1:0] cap [NS];
        int            ldcnt;
        int            runcnt;
        int            oidx;
        logic          done_q;
        logic          outputting;

        assign bus.Din  = din_tb;
        assign bus.Drdy = drdy_tb;
        assign stat     = {bus.Dvld, bus.BSY, bus.Err, cload, crun, cdin};

        simon_share_serdes #(
            .NSHARES (NS),
            .IN_W    (IW),
            .OUT_W   (OW),
            .MASKED  ((g == 0) ? 1 : 0),
            .TIMEOUT (TO)
        ) dut (
            .CLK       (CLK),
            .RSTn      (RSTn),
            .EN        (EN),
            .host      (bus),
            .core_din  (cdin),
            .core_load (cload),
            .core_run  (crun),
            .core_dout (cdout),
            .core_done (cdone)
        );

        // Loopback core: records the first OW loaded bits, raises done on the
        // RunLen-th run cycle, then replays the recorded bits LSB-first.
        always @(posedge CLK) begin
            if (!RSTn) begin
                ldcnt <= 0;
                runcnt <= 0;
                oidx <= 0;
                done_q <= 1'b0;
                outputting <= 1'b0;
            end else if (EN) begin
                if (cload) begin
                    if (ldcnt < int'(OW)) begin
                        for (int s = 0; s < int'(NS); s++) cap[s][ldcnt] <= cdin[s];
                    end
                    ldcnt <= ldcnt + 1;
                end else begin
                    ldcnt <= 0;
                end
                runcnt <= crun ? runcnt + 1 : 0;
                done_q <= crun && (runcnt == int'(RunLen) - 2) && !silent;
                if (done_q && crun) begin
                    outputting <= 1'b1;
                    oidx <= 0;
                end else if (outputting) begin
                    if (oidx == int'(OW) - 1) outputting <= 1'b0;
                    oidx <= oidx + 1;
                end
            end
        end

        always_comb begin
            cdout = '0;
            for (int s = 0; s < int'(NS); s++) cdout[s] = outputting & cap[s][oidx];
        end
        assign cdone = done_q | extra_done;

        if (g == 1) begin : g_lane
            always @(negedge CLK) begin
                if (cload && cdin[NS-1:1] != '0) lane_err <= lane_err + 1;
            end
        end
    end

    // Scoreboard: one expected result is popped per Dvld cycle.
    always @(negedge CLK) begin
        if (g_dut[0].bus.Dvld || g_dut[1].bus.Dvld) begin
            int nq;
            logic [OW-1:0] e;
            dvld_cnt++;
            dvld_cyc = cyc;
            check("dvld_agree", OW'(g_dut[1].bus.Dvld), OW'(g_dut[0].bus.Dvld));
            nq = exp_q.size();
            check("queue_nonempty", OW'(nq != 0), OW'(1));
            if (nq != 0) begin
                e = exp_q.pop_front();
                check("dout_masked", g_dut[0].bus.Dout, e);
                check("dout_unmasked", g_dut[1].bus.Dout, e);
            end
        end
    end

    function automatic logic [IW-1:0] rand256();
        logic [IW-1:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic start_txn(input logic [IW-1:0] a, input logic [IW-1:0] b,
                             input logic [IW-1:0] p, input bit push, output int t);
        @(posedge CLK);
        #1;
        din_tb  = {a ^ b ^ p, b, a};
        drdy_tb = 1'b1;
        t = cyc;
        if (push) exp_q.push_back(p[OW-1:0]);
        @(posedge CLK);
        #1;
        drdy_tb = 1'b0;
    endtask

    task automatic wait_dvld(input int n0, input int budget);
        int k;
        k = 0;
        while (dvld_cnt == n0 && k < budget) begin
            @(negedge CLK);
            #1;
            k++;
        end
        check("dvld_within_budget", OW'(dvld_cnt > n0), OW'(1));
    endtask

    initial begin
        logic [IW-1:0] p, p2, p3, a, b, a2, b2;
        int t;

        p  = 256'h0123456789ABCDEF0123456789ABCDEF0123456789ABCDEF0123456789ABCDEF;
        p2 = rand256();
        p3 = ~p;
        a  = rand256();
        b  = rand256();
        a2 = rand256();
        b2 = rand256();

        RSTn = 1'b0;
        EN = 1'b1;
        drdy_tb = 1'b0;
        din_tb = '0;
        silent = 1'b0;
        extra_done = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("reset_stat_m", OW'(g_dut[0].stat), OW'(0));
        check("reset_stat_u", OW'(g_dut[1].stat), OW'(0));
        check("reset_dout_m", g_dut[0].bus.Dout, '0);
        @(posedge CLK);
        #1;
        RSTn = 1'b1;

        // Basic masked/unmasked loopback with minimum-style latency.
        start_txn(a, b, p, 1'b1, t);
        wait_dvld(0, 1000);
        check("latency_basic", OW'(dvld_cyc - t), OW'(IW + RunLen + OW + 1));
        check("cap_share0", g_dut[0].cap[0], a[OW-1:0]);
        check("cap_share1", g_dut[0].cap[1], b[OW-1:0]);
        check("cap_unmasked_lane0", g_dut[1].cap[0], p[OW-1:0]);
        repeat (3) @(negedge CLK);
        check("dvld_one_cycle", OW'(dvld_cnt), OW'(1));
        check("dout_hold", g_dut[0].bus.Dout, p[OW-1:0]);
        check("idle_stat", OW'(g_dut[0].stat), OW'(0));

        // Drdy re-asserted mid-LOAD is ignored.
        start_txn(a2, b2, p2, 1'b1, t);
        repeat (50) @(posedge CLK);
        #1;
        din_tb = {rand256(), rand256(), rand256()};
        drdy_tb = 1'b1;
        @(posedge CLK);
        #1;
        drdy_tb = 1'b0;
        wait_dvld(1, 1000);
        check("latency_reload", OW'(dvld_cyc - t), OW'(IW + RunLen + OW + 1));
        check("cap_reload_share0", g_dut[0].cap[0], a2[OW-1:0]);
        repeat (3) @(negedge CLK);
        check("dvld_count_reload", OW'(dvld_cnt), OW'(2));

        // EN low for 5 cycles in LOAD and again in UNLOAD.
        start_txn(a, b, p3, 1'b1, t);
        repeat (100) @(posedge CLK);
        #1;
        EN = 1'b0;
        repeat (5) @(posedge CLK);
        #1;
        EN = 1'b1;
        while (cyc < t + 321) @(posedge CLK);
        #1;
        EN = 1'b0;
        repeat (5) @(posedge CLK);
        #1;
        EN = 1'b1;
        wait_dvld(2, 1000);
        check("latency_stall", OW'(dvld_cyc - t), OW'(IW + RunLen + OW + 1 + 10));
        check("lane_zero_unmasked", OW'(lane_err), OW'(0));

        // Core never finishes: timeout after TO RUN cycles.
        silent = 1'b1;
        start_txn(a, b, p, 1'b0, t);
        while (cyc < t + int'(IW + TO)) @(negedge CLK);
        check("last_run_stat", OW'(g_dut[0].stat), OW'(8'h48));
        @(negedge CLK);
        check("timeout_stat_m", OW'(g_dut[0].stat), OW'(8'h20));
        check("timeout_stat_u", OW'(g_dut[1].stat), OW'(8'h20));
        check("timeout_dout", g_dut[0].bus.Dout, p3[OW-1:0]);
        repeat (5) @(negedge CLK);
        check("err_sticky", OW'(g_dut[0].stat), OW'(8'h20));
        check("dvld_count_timeout", OW'(dvld_cnt), OW'(3));
        silent = 1'b0;

        // Next request clears Err.
        start_txn(a2, b2, p, 1'b1, t);
        @(negedge CLK);
        check("err_cleared", OW'(g_dut[0].bus.Err), OW'(0));
        wait_dvld(3, 1000);
        check("latency_after_err", OW'(dvld_cyc - t), OW'(IW + RunLen + OW + 1));

        // Reset mid-RUN aborts; a stray done afterwards is ignored.
        start_txn(a, b, p2, 1'b0, t);
        while (cyc < t + int'(IW) + 4) @(negedge CLK);
        check("mid_run_stat", OW'(g_dut[1].stat), OW'(8'h48));
        @(posedge CLK);
        #1;
        RSTn = 1'b0;
        @(posedge CLK);
        #1;
        RSTn = 1'b1;
        @(negedge CLK);
        check("abort_stat_m", OW'(g_dut[0].stat), OW'(0));
        check("abort_dout_m", g_dut[0].bus.Dout, '0);
        check("abort_dout_u", g_dut[1].bus.Dout, '0);
        @(posedge CLK);
        #1;
        extra_done = 1'b1;
        @(posedge CLK);
        #1;
        extra_done = 1'b0;
        repeat (3) @(negedge CLK);
        check("stray_done_stat", OW'(g_dut[0].stat), OW'(0));
        check("dvld_count_final", OW'(dvld_cnt), OW'(4));
        check("queue_drained", OW'(exp_q.size()), OW'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/simon_share_serdes.md
# simon_share_serdes

Parametrised share-serialising wrapper for bit-serial Simon cores. It latches NSHARES parallel input shares (key‖plaintext) in one cycle and streams them LSB-first into the core, either XOR-recombined (unprotected core) or share-separated (threshold core). It then waits for the core's done pulse with a timeout, deserialises the shared ciphertext into a parallel XOR-recombined result, and reports completion with a one-cycle valid pulse. It sits between the SASEBO host interface and the serial cipher core.

## Interface
- NSHARES, 3: number of Boolean shares per input bit (≥1).
- IN_W, 256: bits per share loaded into the core (key‖plaintext).
- OUT_W, 128: ciphertext bits per share returned by the core.
- MASKED, 1: 1 = core_din/core_dout carry shares separately; 0 = core_din[0] carries XOR of shares, other lanes 0, only core_dout[0] used.
- TIMEOUT, 4096: max cycles in RUN before abort; 0 disables.
- CLK  in  1  single clock; all logic on rising edge.
- RSTn  in  1  reset, synchronous, active-low.
- EN  in  1  global enable; low freezes all state, counters and outputs.
- Din  in  NSHARES*IN_W  shares; share s at Din[s*IN_W +: IN_W].
- Drdy  in  1  input-valid strobe.
- Dout  out  OUT_W  XOR of collected output shares.
- Dvld  out  1  one-cycle result-valid pulse.
- BSY  out  1  high in every state except IDLE.
- Err  out  1  sticky timeout flag.
- core_din  out  NSHARES  serial share bits to core.
- core_load  out  1  high while core_din is valid.
- core_run  out  1  high while waiting for core.
- core_dout  in  NSHARES  serial output share bits from core.
- core_done  in  1  core completion pulse.

## Operation
- States: IDLE, LOAD, RUN, UNLOAD, DONE. Reset (RSTn=0 at edge) → IDLE, counters 0, shift registers 0, Dout=0, Dvld=0, Err=0, all core outputs 0. Reset mid-operation aborts without a Dvld pulse.
- IDLE: EN & Drdy → latch Din into NSHARES shift registers, clear Err, cnt←0, go LOAD. Drdy outside IDLE is ignored; registers are not reloaded.
- LOAD: core_load=1; core_din[s] = bit 0 of share s (MASKED=1), or XOR over s of bit 0 (MASKED=0); registers shift right, zero-filled. After IN_W cycles → RUN, cnt←0.
- RUN: core_run=1; core_done sampled high → UNLOAD, cnt←0. If TIMEOUT≠0 and cnt reaches TIMEOUT-1 without core_done → Err←1, IDLE. core_done on the same cycle as timeout wins (UNLOAD). core_done outside RUN is ignored.
- UNLOAD: each cycle shifts core_dout[s] into the MSB of output register s (right shift). After OUT_W cycles → DONE.
- DONE: Dout ← XOR of all output registers, Dvld=1 for this one cycle, → IDLE. Dout holds until the next DONE or reset.
- Counter width $clog2(max(IN_W,OUT_W,TIMEOUT)+1); no wrap within a phase.

## Timing
- Edge 0: Drdy sampled in IDLE. Cycles 1..IN_W: LOAD, bit k on core_din in cycle k+1.
- Minimum result latency: Drdy edge → Dvld high = IN_W + 1 (RUN, done seen first cycle) + OUT_W + 1 cycles.
- First UNLOAD cycle captures ciphertext bit 0; the core must present it in the cycle after core_done.
- EN low for n cycles stretches every phase by n; no bit is lost or duplicated.

## Structure
- Package simon_ser_pkg: state enum, CNT_W function (clog2 helper), default width constants.
- One sub-module, share_shift_reg: parametrised width, parallel load, right shift with serial in/out, enable; instantiated NSHARES times for input and NSHARES times for output.

## Test plan
- Loopback core model (echoes first OUT_W loaded bits after a 10-cycle run), NSHARES=3, MASKED=1, shares A, B, A^B^P with P=0x0123…EF → Dvld once, Dout=P[127:0], latency 256+10+128+1.
- MASKED=0, same stimulus → core_din[2:1]=0 throughout, core_din[0] equals P bits LSB-first.
- Core never asserts done, TIMEOUT=16 → Err=1 after 16 RUN cycles, BSY falls, no Dvld, Dout unchanged; next Drdy clears Err.
- Drdy re-asserted mid-LOAD with different Din → ignored, result equals first input.
- EN deasserted 5 cycles mid-LOAD and mid-UNLOAD → same Dout, latency +10.
- RSTn low mid-RUN → next cycle IDLE, all outputs 0, later done pulse ignored.
